// File: rtl/sys_defs.sv
// Shared bus definitions: memory command encoding, tag type and owner-table entry.
package sys_defs;

  localparam int unsigned NUM_MEM_TAGS = 16;
  localparam int unsigned TAG_W        = $clog2(NUM_MEM_TAGS);

  typedef logic [TAG_W-1:0] MEM_TAG_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_DCACHE = 1'b0,
    OWNER_ICACHE = 1'b1
  } MEM_OWNER_t;

  typedef struct packed {
    logic       valid;
    MEM_OWNER_t owner;
  } MEM_OWNER_ENTRY_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache/memory side signals of the arbiter. The arbiter takes the slave view; the
// caches plus memory (or a bench) take the master view.
interface mem_bus_arbiter_if import sys_defs::*; ();
  BUS_COMMAND  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  BUS_COMMAND  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  MEM_TAG_t    mem2proc_response;
  logic [63:0] mem2proc_data;
  MEM_TAG_t    mem2proc_tag;

  BUS_COMMAND  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  MEM_TAG_t    Dmem2proc_response;
  MEM_TAG_t    Imem2proc_response;
  MEM_TAG_t    Dmem2proc_tag;
  MEM_TAG_t    Imem2proc_tag;
  logic [63:0] mem2proc_data_out;
  logic        orphan_tag_err;

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  proc2Imem_command, proc2Imem_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output Dmem2proc_response, Imem2proc_response,
    output Dmem2proc_tag, Imem2proc_tag,
    output mem2proc_data_out, orphan_tag_err
  );

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output proc2Imem_command, proc2Imem_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  Dmem2proc_response, Imem2proc_response,
    input  Dmem2proc_tag, Imem2proc_tag,
    input  mem2proc_data_out, orphan_tag_err
  );
endinterface

// File: rtl/mem_tag_owner_table.sv
// Records which cache issued each outstanding load tag and looks up the owner of
// completing tags. A completion with no recorded owner raises a sticky error.
module mem_tag_owner_table import sys_defs::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  MEM_TAG_t   set_tag,
  input  MEM_OWNER_t set_owner,
  input  MEM_TAG_t   cmpl_tag,
  output logic       cmpl_hit,
  output MEM_OWNER_t cmpl_owner,
  output logic       orphan_tag_err
);

  MEM_OWNER_ENTRY_t table_q [NUM_MEM_TAGS];
  MEM_OWNER_ENTRY_t table_d [NUM_MEM_TAGS];
  logic             orphan_q, orphan_d;
  logic             cmpl_req;

  // Lookup of the completing tag against the current table contents.
  always_comb begin
    cmpl_req   = (cmpl_tag != '0);
    cmpl_hit   = cmpl_req && table_q[cmpl_tag].valid;
    cmpl_owner = table_q[cmpl_tag].owner;
  end

  // Next table state: clear on completion, then set, so a re-issue of the same tag wins.
  always_comb begin
    table_d  = table_q;
    orphan_d = orphan_q;
    if (cmpl_hit) begin
      table_d[cmpl_tag].valid = 1'b0;
    end else if (cmpl_req) begin
      orphan_d = 1'b1;
    end
    if (set_en && (set_tag != '0)) begin
      table_d[set_tag] = '{valid: 1'b1, owner: set_owner};
    end
  end

  // Table and sticky error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MEM_TAGS; i++) begin
        table_q[i] <= '{valid: 1'b0, owner: OWNER_DCACHE};
      end
      orphan_q <= 1'b0;
    end else begin
      table_q  <= table_d;
      orphan_q <= orphan_d;
    end
  end

  assign orphan_tag_err = orphan_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between Dcache and Icache. Dcache has priority, but
// an Icache that has been denied STARVE_LIMIT cycles in a row wins the next cycle.
module mem_bus_arbiter import sys_defs::*; #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset,
  mem_bus_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic            d_req, i_req, force_i, grant_i, grant_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  BUS_COMMAND      grant_cmd;
  logic            set_en;
  logic            cmpl_hit;
  MEM_OWNER_t      cmpl_owner;
  logic            orphan;

  // Grant decision for this cycle.
  always_comb begin
    d_req     = (bus.proc2Dmem_command != BUS_NONE);
    i_req     = (bus.proc2Imem_command != BUS_NONE);
    force_i   = i_req && (starve_cnt_q == CntW'(STARVE_LIMIT));
    grant_i   = i_req && (!d_req || force_i);
    grant_d   = d_req && !grant_i;
    grant_cmd = grant_i ? bus.proc2Imem_command
                        : (grant_d ? bus.proc2Dmem_command : BUS_NONE);
    set_en    = !reset && (grant_cmd == BUS_LOAD) && (bus.mem2proc_response != '0);
  end

  // Starvation count: consecutive cycles Icache asked and lost, saturating.
  always_comb begin
    starve_cnt_d = '0;
    if (i_req && !grant_i) begin
      starve_cnt_d = (starve_cnt_q == CntW'(STARVE_LIMIT)) ? starve_cnt_q
                                                             : starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_tag_owner_table u_owner_table (
    .clock          (clock),
    .reset          (reset),
    .set_en         (set_en),
    .set_tag        (bus.mem2proc_response),
    .set_owner      (grant_i ? OWNER_ICACHE : OWNER_DCACHE),
    .cmpl_tag       (bus.mem2proc_tag),
    .cmpl_hit       (cmpl_hit),
    .cmpl_owner     (cmpl_owner),
    .orphan_tag_err (orphan)
  );

  // Memory port drive and response/completion routing; all inactive during reset.
  always_comb begin
    bus.proc2mem_command   = BUS_NONE;
    bus.proc2mem_addr      = '0;
    bus.proc2mem_data      = '0;
    bus.Dmem2proc_response = '0;
    bus.Imem2proc_response = '0;
    bus.Dmem2proc_tag      = '0;
    bus.Imem2proc_tag      = '0;
    bus.mem2proc_data_out  = '0;
    bus.orphan_tag_err     = 1'b0;
    if (!reset) begin
      if (grant_i) begin
        bus.proc2mem_command   = bus.proc2Imem_command;
        bus.proc2mem_addr      = bus.proc2Imem_addr;
        bus.Imem2proc_response = bus.mem2proc_response;
      end else if (grant_d) begin
        bus.proc2mem_command   = bus.proc2Dmem_command;
        bus.proc2mem_addr      = bus.proc2Dmem_addr;
        bus.proc2mem_data      = bus.proc2Dmem_data;
        bus.Dmem2proc_response = bus.mem2proc_response;
      end
      if (cmpl_hit) begin
        if (cmpl_owner == OWNER_ICACHE) begin
          bus.Imem2proc_tag = bus.mem2proc_tag;
        end else begin
          bus.Dmem2proc_tag = bus.mem2proc_tag;
        end
      end
      bus.mem2proc_data_out = bus.mem2proc_data;
      bus.orphan_tag_err    = orphan;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: priority, owner routing, starvation, orphan, reset.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    bus.proc2Dmem_command = BUS_NONE;
    bus.proc2Dmem_addr    = '0;
    bus.proc2Dmem_data    = '0;
    bus.proc2Imem_command = BUS_NONE;
    bus.proc2Imem_addr    = '0;
    bus.mem2proc_response = '0;
    bus.mem2proc_data     = '0;
    bus.mem2proc_tag      = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    bus.proc2Dmem_command = BUS_LOAD;
    bus.proc2Dmem_addr    = 64'h123;
    bus.mem2proc_response = 4'd3;
    bus.mem2proc_data     = 64'hABCD;
    tick();
    tests_run++;
    if (bus.proc2mem_command !== BUS_NONE || bus.proc2mem_addr !== 64'h0 ||
        bus.Dmem2proc_response !== 4'd0 || bus.mem2proc_data_out !== 64'h0 ||
        bus.orphan_tag_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got cmd=%0d addr=%h dresp=%0d data=%h err=%b want all 0",
               bus.proc2mem_command, bus.proc2mem_addr, bus.Dmem2proc_response,
               bus.mem2proc_data_out, bus.orphan_tag_err);
    end
    do_reset();
  endtask

  task automatic test_dcache_priority();
    do_reset();
    bus.proc2Dmem_command = BUS_LOAD;
    bus.proc2Dmem_addr    = 64'h100;
    bus.proc2Imem_command = BUS_LOAD;
    bus.proc2Imem_addr    = 64'h200;
    bus.mem2proc_response = 4'd3;
    #1;
    tests_run++;
    if (bus.proc2mem_addr !== 64'h100 || bus.proc2mem_command !== BUS_LOAD) begin
      tests_failed++;
      $display("FAIL dprio_port got addr=%h cmd=%0d want addr=100 cmd=1",
               bus.proc2mem_addr, bus.proc2mem_command);
    end
    tests_run++;
    if (bus.Dmem2proc_response !== 4'd3 || bus.Imem2proc_response !== 4'd0) begin
      tests_failed++;
      $display("FAIL dprio_resp got d=%0d i=%0d want d=3 i=0",
               bus.Dmem2proc_response, bus.Imem2proc_response);
    end
    tick();
    set_idle();
    bus.mem2proc_tag = 4'd3;
    #1;
    tests_run++;
    if (bus.Dmem2proc_tag !== 4'd3 || bus.Imem2proc_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL dprio_tag got d=%0d i=%0d want d=3 i=0", bus.Dmem2proc_tag, bus.Imem2proc_tag);
    end
    tick();
    set_idle();
  endtask

  task automatic test_icache_alone();
    do_reset();
    bus.proc2Imem_command = BUS_LOAD;
    bus.proc2Imem_addr    = 64'h40;
    bus.mem2proc_response = 4'd5;
    #1;
    tests_run++;
    if (bus.proc2mem_addr !== 64'h40 || bus.proc2mem_data !== 64'h0 ||
        bus.Imem2proc_response !== 4'd5 || bus.Dmem2proc_response !== 4'd0) begin
      tests_failed++;
      $display("FAIL ialone_grant got addr=%h data=%h i=%0d d=%0d want 40 0 5 0",
               bus.proc2mem_addr, bus.proc2mem_data, bus.Imem2proc_response,
               bus.Dmem2proc_response);
    end
    tick();
    set_idle();
    tick();
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = 64'hDEAD;
    #1;
    tests_run++;
    if (bus.Imem2proc_tag !== 4'd5 || bus.Dmem2proc_tag !== 4'd0 ||
        bus.mem2proc_data_out !== 64'hDEAD) begin
      tests_failed++;
      $display("FAIL ialone_cmpl got i=%0d d=%0d data=%h want 5 0 dead",
               bus.Imem2proc_tag, bus.Dmem2proc_tag, bus.mem2proc_data_out);
    end
    tick();
    // Entry 5 is now free: a repeat completion finds no owner.
    #1;
    tests_run++;
    if (bus.Imem2proc_tag !== 4'd0 || bus.Dmem2proc_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL ialone_cleared got i=%0d d=%0d want 0 0", bus.Imem2proc_tag, bus.Dmem2proc_tag);
    end
    tick();
    set_idle();
    tests_run++;
    if (bus.orphan_tag_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ialone_orphan got %b want 1", bus.orphan_tag_err);
    end
  endtask

  task automatic test_starvation();
    logic exp_i;
    do_reset();
    bus.proc2Dmem_command = BUS_LOAD;
    bus.proc2Dmem_addr    = 64'h100;
    bus.proc2Imem_command = BUS_LOAD;
    bus.proc2Imem_addr    = 64'h200;
    bus.mem2proc_response = 4'd1;
    #1;
    for (int c = 1; c <= 10; c++) begin
      exp_i = (c % 5 == 0);
      tests_run++;
      if (bus.Imem2proc_response !== (exp_i ? 4'd1 : 4'd0) ||
          bus.Dmem2proc_response !== (exp_i ? 4'd0 : 4'd1) ||
          bus.proc2mem_addr !== (exp_i ? 64'h200 : 64'h100)) begin
        tests_failed++;
        $display("FAIL starve_cycle%0d got i=%0d d=%0d addr=%h want icache_grant=%b",
                 c, bus.Imem2proc_response, bus.Dmem2proc_response, bus.proc2mem_addr, exp_i);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_store_orphan();
    do_reset();
    bus.proc2Dmem_command = BUS_STORE;
    bus.proc2Dmem_addr    = 64'h80;
    bus.proc2Dmem_data    = 64'h55;
    bus.mem2proc_response = 4'd2;
    #1;
    tests_run++;
    if (bus.proc2mem_command !== BUS_STORE || bus.proc2mem_addr !== 64'h80 ||
        bus.proc2mem_data !== 64'h55 || bus.Dmem2proc_response !== 4'd2) begin
      tests_failed++;
      $display("FAIL store_port got cmd=%0d addr=%h data=%h d=%0d want 2 80 55 2",
               bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data,
               bus.Dmem2proc_response);
    end
    tick();
    set_idle();
    bus.mem2proc_tag = 4'd2;
    #1;
    tests_run++;
    if (bus.Dmem2proc_tag !== 4'd0 || bus.Imem2proc_tag !== 4'd0 ||
        bus.orphan_tag_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_cmpl got d=%0d i=%0d err=%b want 0 0 0",
               bus.Dmem2proc_tag, bus.Imem2proc_tag, bus.orphan_tag_err);
    end
    tick();
    set_idle();
    tick();
    tick();
    tests_run++;
    if (bus.orphan_tag_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_orphan_sticky got %b want 1", bus.orphan_tag_err);
    end
  endtask

  task automatic test_same_cycle_reissue();
    do_reset();
    bus.proc2Imem_command = BUS_LOAD;
    bus.proc2Imem_addr    = 64'h300;
    bus.mem2proc_response = 4'd7;
    tick();
    set_idle();
    bus.proc2Dmem_command = BUS_LOAD;
    bus.proc2Dmem_addr    = 64'h400;
    bus.mem2proc_response = 4'd7;
    bus.mem2proc_tag      = 4'd7;
    #1;
    tests_run++;
    if (bus.Imem2proc_tag !== 4'd7 || bus.Dmem2proc_tag !== 4'd0 ||
        bus.Dmem2proc_response !== 4'd7) begin
      tests_failed++;
      $display("FAIL reissue_same got i=%0d d=%0d dresp=%0d want 7 0 7",
               bus.Imem2proc_tag, bus.Dmem2proc_tag, bus.Dmem2proc_response);
    end
    tick();
    set_idle();
    bus.mem2proc_tag = 4'd7;
    #1;
    tests_run++;
    if (bus.Dmem2proc_tag !== 4'd7 || bus.Imem2proc_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL reissue_owner got d=%0d i=%0d want 7 0", bus.Dmem2proc_tag, bus.Imem2proc_tag);
    end
    tick();
    set_idle();
    tests_run++;
    if (bus.orphan_tag_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reissue_no_orphan got %b want 0", bus.orphan_tag_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.proc2Dmem_command = BUS_LOAD;
    bus.mem2proc_response = 4'd3;
    tick();
    set_idle();
    bus.proc2Imem_command = BUS_LOAD;
    bus.mem2proc_response = 4'd5;
    tick();
    set_idle();
    bus.proc2Dmem_command = BUS_LOAD;
    bus.proc2Dmem_addr    = 64'h500;
    bus.mem2proc_tag      = 4'd5;
    bus.mem2proc_data     = 64'hBEEF;
    #1;
    tests_run++;
    if (bus.Imem2proc_tag !== 4'd5 || bus.proc2mem_addr !== 64'h500) begin
      tests_failed++;
      $display("FAIL midrst_before got i=%0d addr=%h want 5 500", bus.Imem2proc_tag, bus.proc2mem_addr);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.Imem2proc_tag !== 4'd0 || bus.proc2mem_command !== BUS_NONE ||
        bus.proc2mem_addr !== 64'h0 || bus.mem2proc_data_out !== 64'h0) begin
      tests_failed++;
      $display("FAIL midrst_async got i=%0d cmd=%0d addr=%h data=%h want all 0",
               bus.Imem2proc_tag, bus.proc2mem_command, bus.proc2mem_addr,
               bus.mem2proc_data_out);
    end
    #2 reset = 1'b0;
    set_idle();
    bus.mem2proc_tag = 4'd3;
    #1;
    tests_run++;
    if (bus.Dmem2proc_tag !== 4'd0 || bus.Imem2proc_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL midrst_lost got d=%0d i=%0d want 0 0", bus.Dmem2proc_tag, bus.Imem2proc_tag);
    end
    tick();
    set_idle();
    tests_run++;
    if (bus.orphan_tag_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_orphan got %b want 1", bus.orphan_tag_err);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_dcache_priority();
    test_icache_alone();
    test_starvation();
    test_store_orphan();
    test_same_cycle_reissue();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
